regfile_write_ctrl: RTL and testbench
=====================================

REGFILE_WRITE_CTRL -- requirements
Module: regfile_write_ctrl

Interface
REQ-001 SHALL have parameter REGISTER_DEPTH, default 32, number of register-file locations cleared and addressable.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset_b  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port a_valid  input  1  requester A (ALU writeback) write request.
REQ-007 SHALL have port a_addr  input  ADDR_WIDTH  requester A destination register.
REQ-008 SHALL have port a_data  input  DATA_WIDTH  requester A write data.
REQ-009 SHALL have port a_ready  output  1  requester A accepted this cycle (combinational).
REQ-010 SHALL have ports b_valid, b_addr, b_data, b_ready with widths/directions identical to A, for requester B (memory-load writeback).
REQ-011 SHALL have port reg_write  output  1  register-file write enable (registered).
REQ-012 SHALL have port wr_reg  output  ADDR_WIDTH  register-file write address (registered).
REQ-013 SHALL have port wr_data  output  DATA_WIDTH  register-file write data (registered).
REQ-014 SHALL have port init_busy  output  1  clear sweep in progress (registered).

Function
REQ-015 SHALL implement two states: INIT (clear sweep) and RUN (arbitrated writeback).
REQ-016 In INIT, each rising edge SHALL drive reg_write<=1, wr_reg<=cnt, wr_data<=0, cnt<=cnt+1, with cnt starting at 0.
REQ-017 The edge on which cnt==REGISTER_DEPTH-1 SHALL present the last clear write (wr_reg=REGISTER_DEPTH-1), clear init_busy, and enter RUN; the sweep therefore takes exactly REGISTER_DEPTH cycles.
REQ-018 a_ready and b_ready SHALL be 0 whenever state is INIT.
REQ-019 In RUN: a_ready = a_valid & (~b_valid | prio==A); b_ready = b_valid & (~a_valid | prio==B); never both 1 in one cycle.
REQ-020 A transfer SHALL occur on a rising edge where valid&ready for that requester; the next edge's outputs SHALL be wr_reg<=addr, wr_data<=data of the granted requester (one-cycle latency).
REQ-021 reg_write SHALL be 1 on the cycle following a transfer with addr!=0, and 0 for a transfer with addr==0 (r0 hardwired zero; request still consumed).
REQ-022 With no transfer in RUN, reg_write SHALL be 0 and wr_reg/wr_data SHALL hold their previous values.
REQ-023 prio SHALL toggle to the non-granted requester only on edges where both a_valid and b_valid were 1 and a transfer occurred; single-requester grants SHALL NOT change prio.
REQ-024 Full throughput: one transfer per cycle in RUN, no bubble between back-to-back grants.
REQ-025 A requester not granted SHALL keep valid, addr and data stable until ready; the bench SHALL flag violations.

Reset
REQ-026 On reset_b low, immediately and regardless of clk: state=INIT, cnt=0, prio=A, reg_write=0, wr_reg=0, wr_data=0, init_busy=1.
REQ-027 Reset asserted mid-sweep or mid-RUN SHALL abandon any in-flight write and restart the full sweep from register 0 after release.
REQ-028 First rising edge after reset_b release SHALL present the write of register 0.

Verification
REQ-029 Reset release, DEPTH=32, no requests -> reg_write=1 for 32 consecutive cycles, wr_reg 0..31, wr_data=0; init_busy falls with wr_reg=31; readies 0 throughout.
REQ-030 RUN, a_valid only, addr=5, data=0xDEADBEEF -> a_ready=1 same cycle; next cycle reg_write=1, wr_reg=5, wr_data=0xDEADBEEF; prio unchanged.
REQ-031 RUN, both valid for 4 cycles (A addr 1..4, B addr 9..12, A/B holding until accepted), prio=A -> grant order A1,B9,A2,B10; 4 consecutive writes, no idle cycle.
REQ-032 RUN, b_valid addr=0 data=0x1234 -> b_ready=1; next cycle reg_write=0; following request addr=7 proceeds normally.
REQ-033 reset_b pulsed low at sweep cnt=17 and again one cycle after an A transfer -> outputs zero immediately, no write of the pending data, sweep restarts at wr_reg=0.
REQ-034 Random valid/addr/data on both ports for 10,000 cycles with scoreboard model -> every accepted non-zero write appears exactly once, in grant order, never both readies high.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: clears every location after reset, then
// arbitrates ALU (A) and memory-load (B) writebacks onto one write port.
//
// state | meaning
// INIT  | clear sweep, one zero write per cycle from register 0 upward
// RUN   | round-robin arbitration between A and B, one write per cycle
module regfile_write_ctrl #(
  parameter int REGISTER_DEPTH = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] wr_reg,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  init_busy
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic                  PRIO_A   = 1'b0;
  localparam logic                  PRIO_B   = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(REGISTER_DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  prio;
  logic                  in_run;

  assign in_run  = (state == RUN);
  assign a_ready = in_run && a_valid && (!b_valid || (prio == PRIO_A));
  assign b_ready = in_run && b_valid && (!a_valid || (prio == PRIO_B));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= INIT;
      cnt       <= '0;
      prio      <= PRIO_A;
      reg_write <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          reg_write <= 1'b1;
          wr_reg    <= cnt;
          wr_data   <= '0;
          cnt       <= cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_REG) begin
            state     <= RUN;
            init_busy <= 1'b0;
            cnt       <= '0;
          end
        end
        RUN: begin
          // r0 is hardwired zero: the request is consumed but never written
          if (a_ready) begin
            reg_write <= (a_addr != '0);
            wr_reg    <= a_addr;
            wr_data   <= a_data;
          end else if (b_ready) begin
            reg_write <= (b_addr != '0);
            wr_reg    <= b_addr;
            wr_data   <= b_data;
          end else begin
            reg_write <= 1'b0;
          end
          // only contended grants rotate priority to the loser
          if (a_valid && b_valid) begin
            if (a_ready)      prio <= PRIO_B;
            else if (b_ready) prio <= PRIO_A;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: the driver queues expected writes,
// a monitor pops and compares them whenever reg_write is seen high.
module tb_regfile_write_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, reg_write, init_busy;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;

  regfile_write_ctrl #(.REGISTER_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_b(reset_b),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_cnt = 0;
  int  init_left = 0;
  logic m_prio = 1'b0;
  logic pa_pend = 1'b0, pb_pend = 1'b0;
  logic [AW-1:0] pa_addr, pb_addr;
  logic [DW-1:0] pa_data, pb_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_b && reg_write) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got reg %0d data %0h expected no write at %0t",
                   wr_reg, wr_data, $time);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_reg", 64'(wr_reg), 64'(e.addr));
          chk("wr_data", 64'(wr_data), 64'(e.data));
          chk("init_busy", 64'(init_busy), 64'(e.busy));
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic exp_a, input logic exp_b);
    wr_t e;
    if (pa_pend && (!av || aa !== pa_addr || ad !== pa_data)) begin
      n_cmp++; n_bad++;
      $display("FAIL a_stable: requester A changed while waiting at %0t", $time);
    end
    if (pb_pend && (!bv || ba !== pb_addr || bd !== pb_data)) begin
      n_cmp++; n_bad++;
      $display("FAIL b_stable: requester B changed while waiting at %0t", $time);
    end
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    chk("a_ready", 64'(a_ready), 64'(exp_a));
    chk("b_ready", 64'(b_ready), 64'(exp_b));
    if (exp_a && aa != '0) begin e.addr = aa; e.data = ad; e.busy = 1'b0; exp_q.push_back(e); end
    if (exp_b && ba != '0) begin e.addr = ba; e.data = bd; e.busy = 1'b0; exp_q.push_back(e); end
    if (av && bv && (exp_a || exp_b)) m_prio = exp_a;
    pa_pend = av && !exp_a; pa_addr = aa; pa_data = ad;
    pb_pend = bv && !exp_b; pb_addr = ba; pb_data = bd;
    @(posedge clk);
    if (init_left > 0) init_left--;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  // Asserts reset now, checks outputs cleared at once, releases on the next negedge.
  task automatic do_reset();
    wr_t e;
    reset_b = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rst_reg_write", 64'(reg_write), 64'(0));
    chk("rst_wr_reg", 64'(wr_reg), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_init_busy", 64'(init_busy), 64'(1));
    exp_q.delete();
    m_prio = 1'b0; pa_pend = 1'b0; pb_pend = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      e.addr = AW'(i); e.data = '0; e.busy = (i != DEPTH - 1);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    int c0;
    logic ra, rb, ea, eb, run;
    logic [AW-1:0] raa, rba;
    logic [DW-1:0] rad, rbd;

    @(negedge clk);
    do_reset();
    // full sweep with no requests, then ready stays low until RUN
    c0 = wr_cnt;
    idle(DEPTH);
    chk("sweep_writes", 64'(wr_cnt - c0), 64'(DEPTH));
    idle(1);
    chk("idle_no_write", 64'(reg_write), 64'(0));

    // single A request
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 1, 0);
    idle(1);
    chk("hold_wr_reg", 64'(wr_reg), 64'(5));
    chk("hold_wr_data", 64'(wr_data), 64'hDEADBEEF);

    // B to r0 is consumed without a write, then B to r7
    c0 = wr_cnt;
    step(0, '0, '0, 1, 5'd0, 32'h1234, 0, 1);
    chk("r0_no_write", 64'(wr_cnt - c0), 64'(0));
    step(0, '0, '0, 1, 5'd7, 32'h77, 0, 1);
    idle(1);

    // contention starting from prio A, both holding until accepted
    c0 = wr_cnt;
    step(1, 5'd1, 32'hA1, 1, 5'd9,  32'hB9,  1, 0);
    step(1, 5'd2, 32'hA2, 1, 5'd9,  32'hB9,  0, 1);
    step(1, 5'd2, 32'hA2, 1, 5'd10, 32'hB10, 1, 0);
    step(1, 5'd3, 32'hA3, 1, 5'd10, 32'hB10, 0, 1);
    step(1, 5'd3, 32'hA3, 1, 5'd11, 32'hB11, 1, 0);
    step(1, 5'd4, 32'hA4, 1, 5'd11, 32'hB11, 0, 1);
    step(1, 5'd4, 32'hA4, 1, 5'd12, 32'hB12, 1, 0);
    step(0, 5'd0, 32'h0,  1, 5'd12, 32'hB12, 0, 1);
    chk("back_to_back", 64'(wr_cnt - c0), 64'(8));
    idle(1);

    // reset mid-sweep at cnt=17
    do_reset();
    idle(17);
    do_reset();
    idle(DEPTH);

    // reset right after an A transfer kills the presented write
    step(1, 5'd3, 32'hCAFE0003, 0, '0, '0, 1, 0);
    do_reset();
    idle(DEPTH);
    // reset while A is being offered: that transfer never lands
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'hBAD00006;
    #1;
    chk("pre_rst_a_ready", 64'(a_ready), 64'(1));
    do_reset();
    idle(DEPTH);

    // random traffic against the arbitration model
    ra = 0; rb = 0; raa = '0; rba = '0; rad = '0; rbd = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pa_pend) begin
        ra = ($urandom_range(0, 3) != 0);
        raa = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        rad = $urandom;
      end
      if (!pb_pend) begin
        rb = ($urandom_range(0, 3) != 0);
        rba = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        rbd = $urandom;
      end
      run = (init_left == 0);
      ea = run && ra && (!rb || !m_prio);
      eb = run && rb && (!ra || m_prio);
      step(ra, raa, rad, rb, rba, rbd, ea, eb);
    end
    // drain any request still waiting, then let the last write land
    for (int i = 0; i < 4 && (pa_pend || pb_pend); i++) begin
      ra = pa_pend; rb = pb_pend;
      ea = ra && (!rb || !m_prio);
      eb = rb && (!ra || m_prio);
      step(ra, pa_addr, pa_data, rb, pb_addr, pb_data, ea, eb);
    end
    idle(2);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
